// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO, EX register and result register around an external 8-bit ALU
module alu_issue_stage #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    input  logic       acc_clr,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_divz,
    output logic [7:0] acc
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 21;

    logic [FIFO_DEPTH-1:0][EW-1:0] fifo_mem_q, fifo_mem_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic       ex_valid_q, ex_valid_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;

    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_carry_q, res_carry_d;
    logic       res_divz_q, res_divz_d;
    logic [7:0] acc_q, acc_d;

    logic          fifo_full, fifo_empty;
    logic          push, pop, capture, ex_adv;
    logic [EW-1:0] head;
    logic          head_use_acc;
    logic [3:0]    head_op;
    logic [7:0]    head_a, head_b;
    logic          ex_div_zero;
    logic [7:0]    eff_data;
    logic          eff_carry, eff_divz;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full && !reset;
    assign push       = cmd_valid && cmd_ready;

    // EX frees up either by being empty or by handing off to the result register.
    assign capture = ex_valid_q && (!res_valid_q || res_ready);
    assign ex_adv  = !ex_valid_q || capture;
    assign pop     = !fifo_empty && ex_adv;

    assign head = fifo_mem_q[rd_ptr_q];
    assign {head_use_acc, head_op, head_a, head_b} = head;

    // Divide by zero overrides whatever the ALU drives.
    always_comb begin
        ex_div_zero = (alu_sel_q == 4'd3) && (alu_b_q == 8'd0);
        if (ex_div_zero) begin
            eff_data  = 8'hFF;
            eff_carry = 1'b0;
            eff_divz  = 1'b1;
        end else begin
            eff_data  = alu_out;
            eff_carry = (alu_sel_q == 4'd0) && alu_carry;
            eff_divz  = 1'b0;
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A loading behind a valid EX chains off that EX result, not the stale acc.
    always_comb begin
        ex_valid_d = ex_valid_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        if (pop) begin
            ex_valid_d = 1'b1;
            alu_a_d    = head_use_acc ? (ex_valid_q ? eff_data : acc_q) : head_a;
            alu_b_d    = head_b;
            alu_sel_d  = head_op;
        end else if (capture) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        res_valid_d = res_valid_q && !res_ready;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_divz_d  = res_divz_q;
        acc_d       = acc_q;
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = eff_data;
            res_carry_d = eff_carry;
            res_divz_d  = eff_divz;
            acc_d       = eff_data;
        end else if (acc_clr) begin
            acc_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_mem_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ex_valid_q  <= 1'b0;
            alu_a_q     <= 8'd0;
            alu_b_q     <= 8'd0;
            alu_sel_q   <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
            res_carry_q <= 1'b0;
            res_divz_q  <= 1'b0;
            acc_q       <= 8'd0;
        end else begin
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ex_valid_q  <= ex_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_divz_q  <= res_divz_d;
            acc_q       <= acc_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_divz  = res_divz_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic       acc_clr;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_divz;
    logic [7:0] acc;

    alu_issue_stage #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .acc_clr(acc_clr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_carry(res_carry),
        .res_divz(res_divz), .acc(acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in; carry is deliberately noisy on non-add ops.
    function automatic logic [8:0] alu_fn(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (sel)
            4'd0:    alu_fn = {1'b0, a} + {1'b0, b};
            4'd1:    alu_fn = {(a < b), 8'(a - b)};
            4'd2:    alu_fn = {1'b0, p[7:0]};
            4'd3:    alu_fn = (b == 8'd0) ? 9'h100 : {1'b0, 8'(a / b)};
            4'd4:    alu_fn = {1'b0, a & b};
            4'd5:    alu_fn = {1'b0, a | b};
            4'd6:    alu_fn = {1'b0, a ^ b};
            4'd7:    alu_fn = {1'b0, ~a};
            default: alu_fn = {1'b1, a};
        endcase
    endfunction

    logic [8:0] alu_res;
    assign alu_res   = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_out   = alu_res[7:0];
    assign alu_carry = alu_res[8];

    // Expected {carry, divz, data} for one command with its final operand A.
    function automatic logic [9:0] ref_result(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        if (op == 4'd3 && b == 8'd0) return {1'b0, 1'b1, 8'hFF};
        r = alu_fn(op, a, b);
        return {(op == 4'd0) ? r[8] : 1'b0, 1'b0, r[7:0]};
    endfunction

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
        logic [7:0] data;
        logic       carry;
        logic       divz;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic       s_push, s_pop, s_valid;
    logic [9:0] s_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        s_push  = cmd_valid && cmd_ready;
        s_pop   = res_valid && res_ready;
        s_valid = res_valid;
        s_res   = {res_carry, res_divz, res_data};
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        res_ready = 1'b1;
        drive_cmd(v.op, v.a, v.b, v.use_acc);
        cyc();
        check($sformatf("v%0d_push", idx), 32'(s_push), 1);
        cmd_valid = 1'b0;
        check($sformatf("v%0d_lat0", idx), 32'(res_valid), 0);
        cyc();
        check($sformatf("v%0d_lat1", idx), 32'(res_valid), 0);
        cyc();
        check($sformatf("v%0d_valid", idx), 32'(res_valid), 1);
        check($sformatf("v%0d_data", idx), 32'(res_data), 32'(v.data));
        check($sformatf("v%0d_carry", idx), 32'(res_carry), 32'(v.carry));
        check($sformatf("v%0d_divz", idx), 32'(res_divz), 32'(v.divz));
        check($sformatf("v%0d_acc", idx), 32'(acc), 32'(v.data));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[11];
        int         idx;
        logic [7:0] got[$];
        int         pop_cyc[$];
        logic [9:0] exp_q[$];
        logic [7:0] model_acc;
        logic [7:0] op_a;
        logic       prev_stall;
        logic [9:0] prev_res;
        int         seen;

        vecs[0]  = '{4'd0, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
        vecs[1]  = '{4'd1, 8'd5,   8'd9,   1'b0, 8'hFC,  1'b0, 1'b0};
        vecs[2]  = '{4'd3, 8'd9,   8'd0,   1'b0, 8'hFF,  1'b0, 1'b1};
        vecs[3]  = '{4'd3, 8'd9,   8'd2,   1'b0, 8'd4,   1'b0, 1'b0};
        vecs[4]  = '{4'd4, 8'hF0,  8'h3C,  1'b0, 8'h30,  1'b0, 1'b0};
        vecs[5]  = '{4'd0, 8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
        vecs[6]  = '{4'd2, 8'd16,  8'd17,  1'b0, 8'h10,  1'b0, 1'b0};
        vecs[7]  = '{4'd0, 8'h99,  8'd1,   1'b1, 8'h11,  1'b0, 1'b0};
        vecs[8]  = '{4'd3, 8'h42,  8'd0,   1'b1, 8'hFF,  1'b0, 1'b1};
        vecs[9]  = '{4'd9, 8'h5A,  8'h00,  1'b0, 8'h5A,  1'b0, 1'b0};
        vecs[10] = '{4'd1, 8'h00,  8'h5B,  1'b1, 8'hFF,  1'b0, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0;
        cmd_use_acc = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
        repeat (3) cyc();
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_outputs", {res_valid, res_carry, res_divz, res_data, acc, alu_a, alu_b, alu_sel}, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", 32'(cmd_ready), 1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Back-to-back chain through the forwarding path.
        res_ready = 1'b1;
        drive_cmd(4'd0, 8'd5, 8'd3, 1'b0);
        cyc();
        check("chain_push0", 32'(s_push), 1);
        drive_cmd(4'd1, 8'hEE, 8'd2, 1'b1);
        cyc();
        check("chain_push1", 32'(s_push), 1);
        cmd_valid = 1'b0;
        cyc();
        check("chain_r0", {res_valid, res_data}, {1'b1, 8'd8});
        cyc();
        check("chain_r1", {res_valid, res_data}, {1'b1, 8'd6});
        check("chain_acc", 32'(acc), 6);
        cyc();

        // Backpressure: capacity is FIFO + EX + result.
        res_ready = 1'b0;
        idx = 0;
        repeat (12) begin
            if (idx < 8) drive_cmd(4'd0, 8'(idx), 8'd1, 1'b0);
            else cmd_valid = 1'b0;
            cyc();
            if (s_push) idx++;
        end
        check("bp_accepted", idx, 6);
        check("bp_ready_low", 32'(cmd_ready), 0);
        check("bp_frozen", {res_valid, res_data}, {1'b1, 8'd1});
        res_ready = 1'b1;
        for (int t = 0; t < 30 && got.size() < 8; t++) begin
            if (idx < 8) drive_cmd(4'd0, 8'(idx), 8'd1, 1'b0);
            else cmd_valid = 1'b0;
            cyc();
            if (s_push) idx++;
            if (s_pop) begin
                got.push_back(s_res[7:0]);
                pop_cyc.push_back(t);
            end
        end
        cmd_valid = 1'b0;
        check("bp_total_accepted", idx, 8);
        check("bp_total_results", got.size(), 8);
        for (int k = 0; k < got.size(); k++) check($sformatf("bp_res%0d", k), 32'(got[k]), k + 1);
        for (int k = 1; k < 6 && k < pop_cyc.size(); k++)
            check($sformatf("bp_consec%0d", k), pop_cyc[k] - pop_cyc[k-1], 1);
        cyc();
        check("bp_drained", 32'(res_valid), 0);

        // acc_clr alone, then colliding with a capture.
        acc_clr = 1'b1;
        cyc();
        acc_clr = 1'b0;
        check("clr_alone", 32'(acc), 0);
        drive_cmd(4'd0, 8'd3, 8'd4, 1'b0);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        acc_clr = 1'b1;
        cyc();
        acc_clr = 1'b0;
        check("clr_vs_capture", {res_valid, res_data, acc}, {1'b1, 8'd7, 8'd7});
        cyc();
        drive_cmd(4'd0, 8'd0, 8'd1, 1'b1);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        check("clr_then_use_acc", {res_valid, res_data}, {1'b1, 8'd8});
        cyc();

        // Reset with work in flight.
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_cmd(4'd0, 8'(k + 1), 8'h10, 1'b0);
            cyc();
            check($sformatf("rm_push%0d", k), 32'(s_push), 1);
        end
        cmd_valid = 1'b0;
        check("rm_valid_before", 32'(res_valid), 1);
        reset = 1'b1;
        cyc();
        check("rm_outputs", {cmd_ready, res_valid, res_carry, res_divz, res_data, acc, alu_a, alu_b, alu_sel}, 0);
        reset = 1'b0;
        res_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            cyc();
            if (s_valid) seen++;
        end
        check("rm_no_stale", seen, 0);
        run_vec('{4'd0, 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0}, 99);

        // Randomized traffic against an in-order reference.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        model_acc = 8'd0;
        prev_stall = 1'b0;
        prev_res = '0;
        for (int t = 0; t < 400; t++) begin
            cmd_valid   = ($urandom_range(0, 3) != 0);
            cmd_op      = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            cmd_a       = 8'($urandom_range(0, 255));
            cmd_b       = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            cmd_use_acc = ($urandom_range(0, 2) == 0);
            res_ready   = ($urandom_range(0, 3) != 0);
            cyc();
            if (prev_stall) check("rnd_hold", {22'd0, s_res}, {22'd0, prev_res});
            prev_stall = s_valid && !s_pop;
            prev_res   = s_res;
            if (s_push) begin
                op_a = cmd_use_acc ? model_acc : cmd_a;
                exp_q.push_back(ref_result(cmd_op, op_a, cmd_b));
                model_acc = exp_q[$][7:0];
            end
            if (s_pop) begin
                if (exp_q.size() == 0) check("rnd_spurious", 1, 0);
                else check("rnd_result", {22'd0, s_res}, {22'd0, exp_q.pop_front()});
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            cyc();
            if (s_pop) begin
                if (exp_q.size() == 0) check("rnd_spurious", 1, 0);
                else check("rnd_result", {22'd0, s_res}, {22'd0, exp_q.pop_front()});
            end
        end
        check("rnd_all_done", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
